// File: rtl/morra_tabellone.sv
// -----------------------------------------------------------------------------
// morra_tabellone
//   Scoreboard stage placed after the Morra Cinese game FSM. It samples the
//   per-round result (manche) and the match result (partita) every clock. It
//   accumulates per-player round wins, draws, the valid-round total and the
//   current winning streak, and it latches the final match outcome. The
//   outputs drive display/report logic only; nothing feeds back into the game.
//
// Ports
//   clk           in   1        rising-edge clock
//   in            in   1        synchronous active-high reset (new game)
//   manche        in   2        round result: 00 none, 01 P1, 10 P2, 11 draw
//   partita       in   2        match result: 00 running, 01 P1, 10 P2, 11 draw
//   vinte_primo   out  CNT_W    rounds won by player 1 (saturating)
//   vinte_secondo out  CNT_W    rounds won by player 2 (saturating)
//   pareggi       out  CNT_W    drawn rounds (saturating)
//   valide        out  CNT_W    valid rounds, manche != 00 (saturating)
//   serie         out  SERIE_W  current consecutive-win streak length
//   serie_chi     out  2        streak owner: 00 none, 01 P1, 10 P2
//   fine          out  1        match finished (latched)
//   vincitore     out  2        partita value latched at match end
//
// Build option
//   TABELLONE_SERIE_EN  when defined the streak tracker is built; otherwise
//                       serie and serie_chi are tied to zero.
//
// All outputs are registered: each update appears one edge after sampling.
// -----------------------------------------------------------------------------
module morra_tabellone #(
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned SERIE_W = 3
) (
  input  logic               clk,
  input  logic               in,
  input  logic [1:0]         manche,
  input  logic [1:0]         partita,
  output logic [CNT_W-1:0]   vinte_primo,
  output logic [CNT_W-1:0]   vinte_secondo,
  output logic [CNT_W-1:0]   pareggi,
  output logic [CNT_W-1:0]   valide,
  output logic [SERIE_W-1:0] serie,
  output logic [1:0]         serie_chi,
  output logic               fine,
  output logic [1:0]         vincitore
);

  typedef enum logic [1:0] {
    ATTESA = 2'b00,
    GIOCO  = 2'b01,
    FINE   = 2'b10
  } stato_t;

  // Round result codes
  localparam logic [1:0] M_NONE = 2'b00;
  localparam logic [1:0] M_P1   = 2'b01;
  localparam logic [1:0] M_P2   = 2'b10;
  localparam logic [1:0] M_DRAW = 2'b11;

  stato_t             stato_q;
  logic [CNT_W-1:0]   vp_q;
  logic [CNT_W-1:0]   vs_q;
  logic [CNT_W-1:0]   par_q;
  logic [CNT_W-1:0]   val_q;
  logic               fine_q;
  logic [1:0]         vinc_q;

  // Rounds are only counted while the match is live.
  logic               attivo;
  assign attivo = (stato_q == ATTESA) || (stato_q == GIOCO);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Match FSM with registered counters and latched outcome
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (in) begin
      stato_q <= ATTESA;
      vp_q    <= '0;
      vs_q    <= '0;
      par_q   <= '0;
      val_q   <= '0;
      fine_q  <= 1'b0;
      vinc_q  <= '0;
    end else begin
      case (stato_q)
        ATTESA, GIOCO: begin
          // The round sampled alongside a match end is still counted.
          unique case (manche)
            M_P1: begin
              vp_q  <= sat_inc(vp_q);
              val_q <= sat_inc(val_q);
            end
            M_P2: begin
              vs_q  <= sat_inc(vs_q);
              val_q <= sat_inc(val_q);
            end
            M_DRAW: begin
              par_q <= sat_inc(par_q);
              val_q <= sat_inc(val_q);
            end
            default: ;
          endcase

          if (partita != 2'b00) begin
            stato_q <= FINE;
            fine_q  <= 1'b1;
            vinc_q  <= partita;
          end else if (manche != M_NONE) begin
            stato_q <= GIOCO;
          end
        end

        FINE: begin
          // Everything holds until the next reset.
          stato_q <= FINE;
        end

        default: begin
          stato_q <= ATTESA;
        end
      endcase
    end
  end

  assign vinte_primo   = vp_q;
  assign vinte_secondo = vs_q;
  assign pareggi       = par_q;
  assign valide        = val_q;
  assign fine          = fine_q;
  assign vincitore     = vinc_q;

  // ---------------------------------------------------------------------------
  // Winning-streak tracker
  // ---------------------------------------------------------------------------
`ifdef TABELLONE_SERIE_EN
  logic [SERIE_W-1:0] serie_q, serie_d;
  logic [1:0]         chi_q,   chi_d;

  always_comb begin
    serie_d = serie_q;
    chi_d   = chi_q;
    if (attivo) begin
      unique case (manche)
        M_P1, M_P2: begin
          if (manche == chi_q) begin
            serie_d = (serie_q == '1) ? serie_q : serie_q + SERIE_W'(1);
          end else begin
            serie_d = SERIE_W'(1);
            chi_d   = manche;
          end
        end
        M_DRAW: begin
          serie_d = '0;
          chi_d   = 2'b00;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (in) begin
      serie_q <= '0;
      chi_q   <= '0;
    end else begin
      serie_q <= serie_d;
      chi_q   <= chi_d;
    end
  end

  assign serie     = serie_q;
  assign serie_chi = chi_q;
`else
  logic unused_attivo;
  assign unused_attivo = attivo;
  assign serie         = '0;
  assign serie_chi     = '0;
`endif

endmodule

// File: doc/morra_tabellone.md
Name: morra_tabellone

Overview:
- Scoreboard stage directly downstream of the Morra Cinese game FSM.
- Samples the game's per-round result (manche) and match result (partita) every clock.
- Accumulates per-player round wins, draws, valid-round total and current winning streak; latches the final match outcome.
- Outputs drive the display/report logic; the block never feeds back into the game.

Parameters:
- CNT_W, 5, width of round counters; wide enough for the game's maximum round total.
- SERIE_W, 3, width of the streak counter.

Ports:
- clk  input  1  system clock, rising-edge.
- in  input  1  synchronous active-high reset; same signal that starts a new game upstream.
- manche  input  2  round result from game: 00 none/invalid, 01 player 1, 10 player 2, 11 draw.
- partita  input  2  match result from game: 00 in progress, 01 player 1 wins, 10 player 2 wins, 11 draw.
- vinte_primo  output  CNT_W  rounds won by player 1.
- vinte_secondo  output  CNT_W  rounds won by player 2.
- pareggi  output  CNT_W  drawn rounds.
- valide  output  CNT_W  total valid rounds (manche != 00).
- serie  output  SERIE_W  length of current consecutive-win streak.
- serie_chi  output  2  owner of streak: 00 none, 01 player 1, 10 player 2.
- fine  output  1  match finished, latched.
- vincitore  output  2  latched partita value at match end; 00 while in progress.

Behaviour:
- All outputs are registered; every update becomes visible on the clock edge after the inputs are sampled (latency 1).
- Reset: when in=1 at a rising edge, all outputs go to 0 and the state goes to ATTESA. in takes priority over manche/partita sampled in the same cycle. Reset mid-match clears everything in one cycle.
- States:
  - ATTESA=00: no valid round seen yet.
  - GIOCO=01: at least one valid round counted.
  - FINE=10: match over.
  - Encoding 11 is unreachable; if entered, go to ATTESA.
- ATTESA -> GIOCO on the first manche != 00. ATTESA/GIOCO -> FINE when partita != 00. FINE -> FINE until in=1.
- Round counting (ATTESA/GIOCO only):
  - manche=01: vinte_primo+1, valide+1.
  - manche=10: vinte_secondo+1, valide+1.
  - manche=11: pareggi+1, valide+1.
  - manche=00: no change.
- Counters saturate at 2^CNT_W-1; no wrap-around.
- Streak:
  - manche=01/10 matching serie_chi: serie+1, saturating at 2^SERIE_W-1.
  - manche=01/10 with a different owner or none: serie=1, serie_chi=manche.
  - manche=11: serie=0, serie_chi=00.
  - manche=00: hold.
- Match end: on the cycle partita != 00 is sampled in ATTESA/GIOCO:
  - fine=1 and vincitore=partita on the next edge.
  - The manche sampled in the same cycle is still counted.
- In FINE, manche and partita are ignored entirely. All counters, streak, fine and vincitore hold.
- partita=11 (upstream all-rounds-played draw) latches vincitore=11 like any other end value.

Optional Feature:
- Macro TABELLONE_SERIE_EN.
- Defined: streak logic present exactly as above.
- Undefined: no streak registers are synthesised; serie and serie_chi are tied to 0. All other behaviour is unchanged.

Test Plan:
- Reset then manche sequence 01,01,01 with partita=00 -> vinte_primo=3, valide=3, serie=3, serie_chi=01, state GIOCO, fine=0.
- Sequence 01,10,11,10 -> vinte_primo=1, vinte_secondo=2, pareggi=1, valide=4. Final streak serie=1, serie_chi=10; after the 11 round, serie=0 and serie_chi=00.
- manche=10 together with partita=10 after 3 prior P2 wins -> next edge vinte_secondo=4, fine=1, vincitore=10. Further manche=01 inputs change nothing.
- in=1 asserted mid-match with manche=01 in the same cycle -> all outputs 0, state ATTESA. The following manche=01 gives vinte_primo=1.
- 40 consecutive manche=11 without partita -> pareggi saturates at 31, valide=31, serie=0.
- Build without TABELLONE_SERIE_EN, sequence 01,01 -> serie=0 and serie_chi=00; vinte_primo=2.
